// File: rtl/result_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_acc_pkg : shared types and sizing helper for result_window_acc |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package result_acc_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

    // The sum carries log2(WINDOW) extra bits so a full window cannot overflow.
    function automatic int sum_width(input int data_w, input int window);
        return data_w + $clog2(window);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : first-word fall-through FIFO with wrap-bit pointers       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int                c_aw    = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]     c_depth = (c_aw+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw:0]     r_wr_ptr;
    logic [c_aw:0]     r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign level     = r_wr_ptr - r_rd_ptr;
    assign full      = (level == c_depth);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign rdata     = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_do_pop  = pop && !empty;
    // A push into a full FIFO is allowed when a pop frees a slot on the same edge.
    assign w_do_push = push && !clear && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/result_window_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_window_acc : buffers a result stream and emits WINDOW sums     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module result_window_acc
    import result_acc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int WINDOW     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [DATA_W-1:0]                    result,
    input  logic                                 result_valid,
    output logic [sum_width(DATA_W, WINDOW)-1:0] sum,
    output logic [DATA_W-1:0]                    avg,
    output logic                                 sum_valid,
    input  logic                                 sum_ready,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
    output logic                                 drop_err
);

    localparam int                 c_sum_w    = sum_width(DATA_W, WINDOW);
    localparam int                 c_cnt_w    = $clog2(WINDOW);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WINDOW - 1);

    acc_state_e         r_state;
    acc_state_e         w_next_state;
    logic [c_sum_w-1:0] r_acc;
    logic [c_sum_w-1:0] w_acc_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic               w_handshake;
    logic               w_drop;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (result),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // clear outranks both the incoming result and any handshake.
    assign w_push    = result_valid && !clear && (!w_full || w_pop);
    assign w_drop    = result_valid && !clear && w_full && !w_pop;
    assign w_acc_sum = r_acc + c_sum_w'(w_rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_state <= ACC;
        else if (clear) r_state <= ACC;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ACC:     if (!w_empty && (r_cnt == c_cnt_last)) w_next_state = HOLD;
            HOLD:    if (sum_ready) w_next_state = ACC;
            default: w_next_state = ACC;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_handshake = 1'b0;
        w_last      = 1'b0;
        if (!clear) begin
            w_pop       = (r_state == ACC) && !w_empty;
            w_handshake = (r_state == HOLD) && sum_valid && sum_ready;
            w_last      = w_pop && (r_cnt == c_cnt_last);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clear || w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_pop) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // sum/avg are only loaded on window completion, so they survive clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            avg <= '0;
        end else if (w_last) begin
            sum <= w_acc_sum;
            avg <= DATA_W'(w_acc_sum >> c_cnt_w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_valid <= 1'b0;
            drop_err  <= 1'b0;
        end else if (clear) begin
            sum_valid <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (w_last)           sum_valid <= 1'b1;
            else if (w_handshake) sum_valid <= 1'b0;
            if (w_drop)           drop_err  <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_window_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_result_window_acc : directed cycle-by-cycle vectors for the DUT    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_result_window_acc;

    typedef struct {
        logic        clr;
        logic        rv;
        logic [15:0] res;
        logic        rdy;
        logic        e_sv;
        logic [17:0] e_sum;
        logic [15:0] e_avg;
        logic [2:0]  e_lvl;
        logic        e_drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] result = '0;
    logic        result_valid = 1'b0;
    logic [17:0] sum;
    logic [15:0] avg;
    logic        sum_valid;
    logic        sum_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic        drop_err;

    int n_pass  = 0;
    int n_total = 0;
    vec_t tv[$];

    result_window_acc #(
        .DATA_W     (16),
        .WINDOW     (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .result       (result),
        .result_valid (result_valid),
        .sum          (sum),
        .avg          (avg),
        .sum_valid    (sum_valid),
        .sum_ready    (sum_ready),
        .fifo_level   (fifo_level),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic clr, input logic rv, input logic [15:0] res, input logic rdy,
                       input logic e_sv, input logic [17:0] e_sum, input logic [15:0] e_avg,
                       input logic [2:0] e_lvl, input logic e_drop);
        vec_t v;
        v.clr = clr; v.rv = rv; v.res = res; v.rdy = rdy;
        v.e_sv = e_sv; v.e_sum = e_sum; v.e_avg = e_avg; v.e_lvl = e_lvl; v.e_drop = e_drop;
        tv.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare the settled outputs.
    task automatic apply(input vec_t v, input int idx);
        clear        = v.clr;
        result_valid = v.rv;
        result       = v.res;
        sum_ready    = v.rdy;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.sum_valid", idx), {31'd0, sum_valid}, {31'd0, v.e_sv});
        chk($sformatf("v%0d.sum", idx), {14'd0, sum}, {14'd0, v.e_sum});
        chk($sformatf("v%0d.avg", idx), {16'd0, avg}, {16'd0, v.e_avg});
        chk($sformatf("v%0d.fifo_level", idx), {29'd0, fifo_level}, {29'd0, v.e_lvl});
        chk($sformatf("v%0d.drop_err", idx), {31'd0, drop_err}, {31'd0, v.e_drop});
    endtask

    initial begin
        vec_t v;

        // Basic window 1,2,3,4 with ready held high
        add(0,1,16'd1,1, 0,18'd0,16'd0,3'd1,0);
        add(0,1,16'd2,1, 0,18'd0,16'd0,3'd1,0);
        add(0,1,16'd3,1, 0,18'd0,16'd0,3'd1,0);
        add(0,1,16'd4,1, 0,18'd0,16'd0,3'd1,0);
        add(0,0,16'd0,1, 1,18'd10,16'd2,3'd0,0);
        add(0,0,16'd0,1, 0,18'd10,16'd2,3'd0,0);
        // Maximum values: no overflow
        for (int i = 0; i < 4; i++) add(0,1,16'hFFFF,1, 0,18'd10,16'd2,3'd1,0);
        add(0,0,16'd0,1, 1,18'h3FFFC,16'hFFFF,3'd0,0);
        add(0,0,16'd0,1, 0,18'h3FFFC,16'hFFFF,3'd0,0);
        // Stall in HOLD, fill FIFO exactly, then push alongside the resumed pop
        add(0,1,16'd1,0, 0,18'h3FFFC,16'hFFFF,3'd1,0);
        add(0,1,16'd2,0, 0,18'h3FFFC,16'hFFFF,3'd1,0);
        add(0,1,16'd3,0, 0,18'h3FFFC,16'hFFFF,3'd1,0);
        add(0,1,16'd4,0, 0,18'h3FFFC,16'hFFFF,3'd1,0);
        add(0,0,16'd0,0, 1,18'd10,16'd2,3'd0,0);
        add(0,1,16'd5,0, 1,18'd10,16'd2,3'd1,0);
        add(0,1,16'd6,0, 1,18'd10,16'd2,3'd2,0);
        add(0,1,16'd7,0, 1,18'd10,16'd2,3'd3,0);
        add(0,1,16'd8,0, 1,18'd10,16'd2,3'd4,0);
        add(0,0,16'd0,1, 0,18'd10,16'd2,3'd4,0);
        add(0,1,16'd9,0, 0,18'd10,16'd2,3'd4,0);
        add(0,0,16'd0,0, 0,18'd10,16'd2,3'd3,0);
        add(0,0,16'd0,0, 0,18'd10,16'd2,3'd2,0);
        add(0,0,16'd0,0, 1,18'd26,16'd6,3'd1,0);
        // Overfill while stalled: fifth result dropped, sum held
        add(0,1,16'd20,0, 1,18'd26,16'd6,3'd2,0);
        add(0,1,16'd21,0, 1,18'd26,16'd6,3'd3,0);
        add(0,1,16'd22,0, 1,18'd26,16'd6,3'd4,0);
        add(0,1,16'd23,0, 1,18'd26,16'd6,3'd4,1);
        add(0,0,16'd0,1, 0,18'd26,16'd6,3'd4,1);
        add(0,0,16'd0,0, 0,18'd26,16'd6,3'd3,1);
        add(0,0,16'd0,0, 0,18'd26,16'd6,3'd2,1);
        add(0,0,16'd0,0, 0,18'd26,16'd6,3'd1,1);
        add(0,0,16'd0,0, 1,18'd72,16'd18,3'd0,1);
        add(0,0,16'd0,1, 0,18'd72,16'd18,3'd0,1);
        // Partial window then clear with a coincident result
        add(0,1,16'd3,1, 0,18'd72,16'd18,3'd1,1);
        add(0,1,16'd4,1, 0,18'd72,16'd18,3'd1,1);
        add(1,1,16'd99,1, 0,18'd72,16'd18,3'd0,0);
        add(0,1,16'd5,1, 0,18'd72,16'd18,3'd1,0);
        add(0,1,16'd6,1, 0,18'd72,16'd18,3'd1,0);
        add(0,1,16'd7,1, 0,18'd72,16'd18,3'd1,0);
        add(0,1,16'd8,1, 0,18'd72,16'd18,3'd1,0);
        add(0,0,16'd0,1, 1,18'd26,16'd6,3'd0,0);
        // clear beats the handshake and the arriving result
        add(1,1,16'd50,1, 0,18'd26,16'd6,3'd0,0);
        add(0,0,16'd0,1, 0,18'd26,16'd6,3'd0,0);

        #12;
        rst = 1'b0;
        #1;
        chk("reset.sum", {14'd0, sum}, 32'd0);
        chk("reset.avg", {16'd0, avg}, 32'd0);
        chk("reset.sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("reset.fifo_level", {29'd0, fifo_level}, 32'd0);
        chk("reset.drop_err", {31'd0, drop_err}, 32'd0);

        foreach (tv[i]) apply(tv[i], i);

        // Asynchronous reset in the middle of a window
        v.clr = 0; v.rv = 1; v.res = 16'd1; v.rdy = 1;
        v.e_sv = 0; v.e_sum = 18'd26; v.e_avg = 16'd6; v.e_lvl = 3'd1; v.e_drop = 0;
        for (int i = 0; i < 3; i++) apply(v, 100 + i);
        result_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.sum", {14'd0, sum}, 32'd0);
        chk("async_rst.avg", {16'd0, avg}, 32'd0);
        chk("async_rst.sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("async_rst.fifo_level", {29'd0, fifo_level}, 32'd0);
        chk("async_rst.drop_err", {31'd0, drop_err}, 32'd0);
        #1;
        rst = 1'b0;
        v.e_sum = 18'd0; v.e_avg = 16'd0;
        for (int i = 0; i < 4; i++) apply(v, 200 + i);
        v.rv = 0; v.e_sv = 1; v.e_sum = 18'd4; v.e_avg = 16'd1; v.e_lvl = 3'd0;
        apply(v, 204);
        v.e_sv = 0;
        apply(v, 205);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
